// File: rtl/qdrc_bit_deskew_pkg.sv
// Shared types for the QDR per-bit read-capture deskew trainer.
// Holds the state and error codes plus the sample validity rule.
package qdrc_bit_deskew_pkg;

  typedef enum logic [3:0] {
    StIdle   = 4'd0,
    StBitRst = 4'd1,
    StSettle = 4'd2,
    StSample = 4'd3,
    StStep   = 4'd4,
    StCalc   = 4'd5,
    StBack   = 4'd6,
    StVerify = 4'd7,
    StNext   = 4'd8,
    StDone   = 4'd9
  } state_e;

  typedef enum logic [3:0] {
    ErrNone        = 4'd0,
    ErrNoWindow    = 4'd1,
    ErrInvalCentre = 4'd2
  } err_e;

  // A capture is usable only when rise and fall disagree.
  function automatic logic valid(input logic [1:0] s);
    return s[1] ^ s[0];
  endfunction

endpackage

// File: rtl/qdrc_bit_window_tracker.sv
// Tracks the longest run of good, same-pattern taps during one bit sweep.
// Results are registered and valid the cycle after the last strobe.
module qdrc_bit_window_tracker
  import qdrc_bit_deskew_pkg::*;
#(
  parameter int unsigned TAPW = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            strobe,
  input  logic            good,
  input  logic [1:0]      pattern,
  input  logic [TAPW-1:0] tap,
  output logic [TAPW-1:0] best_start,
  output logic [TAPW:0]   best_len
);

  logic [TAPW-1:0] cur_start_q, cur_start_d;
  logic [TAPW-1:0] best_start_q, best_start_d;
  logic [TAPW:0]   cur_len_q, cur_len_d;
  logic [TAPW:0]   best_len_q, best_len_d;
  logic [1:0]      cur_pat_q, cur_pat_d;

  always_comb begin
    cur_start_d  = cur_start_q;
    cur_len_d    = cur_len_q;
    cur_pat_d    = cur_pat_q;
    best_start_d = best_start_q;
    best_len_d   = best_len_q;
    if (clear) begin
      cur_start_d  = '0;
      cur_len_d    = '0;
      cur_pat_d    = '0;
      best_start_d = '0;
      best_len_d   = '0;
    end else if (strobe) begin
      if (!good) begin
        cur_len_d = '0;
      end else if ((cur_len_q != '0) && (pattern == cur_pat_q)) begin
        cur_len_d = cur_len_q + 1'b1;
      end else begin
        cur_start_d = tap;
        cur_len_d   = (TAPW+1)'(1);
        cur_pat_d   = pattern;
      end
      // Comparing the growing run every strobe closes the last run implicitly;
      // strict compare keeps the lowest start on ties.
      if (cur_len_d > best_len_q) begin
        best_len_d   = cur_len_d;
        best_start_d = cur_start_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_start_q  <= '0;
      cur_len_q    <= '0;
      cur_pat_q    <= '0;
      best_start_q <= '0;
      best_len_q   <= '0;
    end else begin
      cur_start_q  <= cur_start_d;
      cur_len_q    <= cur_len_d;
      cur_pat_q    <= cur_pat_d;
      best_start_q <= best_start_d;
      best_len_q   <= best_len_d;
    end
  end

  assign best_start = best_start_q;
  assign best_len   = best_len_q;

endmodule

// File: rtl/qdrc_phy_bit_deskew.sv
// Per-bit IODELAY read-capture trainer: sweeps each bit, finds the widest
// stable eye, centres the delay in it and reports results via readback.
module qdrc_phy_bit_deskew
  import qdrc_bit_deskew_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 36,
  parameter int unsigned NTAPS         = 32,
  parameter int unsigned TAPW          = 5,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned SAMPLE_CYCLES = 16,
  parameter int unsigned MIN_WINDOW    = 4,
  localparam int unsigned BitW         = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  train_start,
  output logic                  train_done,
  output logic                  train_fail,
  input  logic [DATA_WIDTH-1:0] q_rise,
  input  logic [DATA_WIDTH-1:0] q_fall,
  output logic [DATA_WIDTH-1:0] dly_inc_dec_n,
  output logic [DATA_WIDTH-1:0] dly_en,
  output logic [DATA_WIDTH-1:0] dly_rst,
  output logic [DATA_WIDTH-1:0] aligned,
  output logic [DATA_WIDTH-1:0] bit_fail,
  input  logic [BitW-1:0]       rd_bit_sel,
  output logic [TAPW-1:0]       rd_tap,
  output logic [TAPW:0]         rd_win,
  output logic [3:0]            state_prb,
  output logic [3:0]            error_prb
);

  localparam int unsigned MaxCnt = (SETTLE_CYCLES > SAMPLE_CYCLES) ? SETTLE_CYCLES : SAMPLE_CYCLES;
  localparam int unsigned CntW   = $clog2(MaxCnt + 1);

  state_e                state_q, state_d;
  err_e                  err_q, err_d;
  logic [BitW-1:0]       bit_idx_q, bit_idx_d;
  logic [TAPW-1:0]       tap_q, tap_d;
  logic [TAPW-1:0]       target_q, target_d;
  logic [TAPW:0]         len_q, len_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [1:0]            first_q, first_d;
  logic                  good_q, good_d;
  logic                  rst_mode_q, rst_mode_d;
  logic                  phase_q, phase_d;
  logic                  inc_q, inc_d;
  logic [DATA_WIDTH-1:0] dly_en_q, dly_en_d;
  logic [DATA_WIDTH-1:0] dly_rst_q, dly_rst_d;
  logic [DATA_WIDTH-1:0] aligned_q, aligned_d;
  logic [DATA_WIDTH-1:0] bit_fail_q, bit_fail_d;
  logic [DATA_WIDTH-1:0] bit_onehot;

  logic [DATA_WIDTH-1:0] rise1_q, fall1_q, rise2_q, fall2_q;
  logic [1:0]            samp_q;

  logic [TAPW-1:0]       tap_mem [DATA_WIDTH];
  logic [TAPW:0]         win_mem [DATA_WIDTH];
  logic                  mem_we, mem_clear;
  logic [TAPW-1:0]       rd_tap_q;
  logic [TAPW:0]         rd_win_q;

  logic                  trk_clear, trk_strobe, trk_good;
  logic [1:0]            trk_pat;
  logic [TAPW-1:0]       best_start;
  logic [TAPW:0]         best_len;

  assign bit_onehot = DATA_WIDTH'(1) << bit_idx_q;

  // Two sync stages on the IDDR outputs, then the bit mux into one more flop.
  always_ff @(posedge clk) begin
    rise1_q <= q_rise;
    fall1_q <= q_fall;
    rise2_q <= rise1_q;
    fall2_q <= fall1_q;
    samp_q  <= {rise2_q[bit_idx_q], fall2_q[bit_idx_q]};
  end

  qdrc_bit_window_tracker #(
    .TAPW (TAPW)
  ) u_tracker (
    .clk        (clk),
    .reset      (reset),
    .clear      (trk_clear),
    .strobe     (trk_strobe),
    .good       (trk_good),
    .pattern    (trk_pat),
    .tap        (tap_q),
    .best_start (best_start),
    .best_len   (best_len)
  );

  always_comb begin
    state_d    = state_q;
    err_d      = err_q;
    bit_idx_d  = bit_idx_q;
    tap_d      = tap_q;
    target_d   = target_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    first_d    = first_q;
    good_d     = good_q;
    rst_mode_d = rst_mode_q;
    phase_d    = phase_q;
    inc_d      = inc_q;
    dly_en_d   = '0;
    dly_rst_d  = '0;
    aligned_d  = aligned_q;
    bit_fail_d = bit_fail_q;
    trk_clear  = 1'b0;
    trk_strobe = 1'b0;
    trk_good   = 1'b0;
    trk_pat    = first_q;
    mem_we     = 1'b0;
    mem_clear  = 1'b0;

    case (state_q)
      StIdle, StDone: begin
        if (train_start) begin
          aligned_d  = '1;
          bit_fail_d = '0;
          err_d      = ErrNone;
          bit_idx_d  = '0;
          mem_clear  = 1'b1;
          state_d    = StBitRst;
        end
      end
      StBitRst: begin
        dly_rst_d = bit_onehot;
        tap_d     = '0;
        trk_clear = 1'b1;
        cnt_d     = '0;
        state_d   = StSettle;
      end
      StSettle: begin
        if (cnt_q == CntW'(SETTLE_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = StSample;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StSample: begin
        if (cnt_q == '0) begin
          first_d = samp_q;
          good_d  = valid(samp_q);
        end else begin
          good_d = good_q & valid(samp_q) & (samp_q == first_q);
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(SAMPLE_CYCLES - 1)) begin
          trk_strobe = 1'b1;
          trk_good   = good_d;
          trk_pat    = first_d;
          cnt_d      = '0;
          state_d    = (tap_q == TAPW'(NTAPS - 1)) ? StCalc : StStep;
        end
      end
      StStep: begin
        dly_en_d = bit_onehot;
        inc_d    = 1'b1;
        tap_d    = tap_q + 1'b1;
        cnt_d    = '0;
        state_d  = StSettle;
      end
      StCalc: begin
        len_d      = best_len;
        phase_d    = 1'b0;
        rst_mode_d = 1'b0;
        target_d   = best_start + TAPW'((best_len - 1'b1) >> 1);
        if (best_len < (TAPW+1)'(MIN_WINDOW)) begin
          bit_fail_d[bit_idx_q] = 1'b1;
          if (err_q == ErrNone) err_d = ErrNoWindow;
          if (best_len == '0) begin
            target_d   = '0;
            rst_mode_d = 1'b1;
          end
        end
        state_d = StBack;
      end
      StBack: begin
        // Empty sweep: a single reset is cheaper than stepping down 31 taps.
        if (rst_mode_q) begin
          dly_rst_d = bit_onehot;
          tap_d     = '0;
          cnt_d     = '0;
          state_d   = StVerify;
        end else if (tap_q == target_q) begin
          cnt_d   = '0;
          state_d = StVerify;
        end else if (!phase_q) begin
          dly_en_d = bit_onehot;
          inc_d    = 1'b0;
          tap_d    = tap_q - 1'b1;
          phase_d  = 1'b1;
        end else begin
          phase_d = 1'b0;
        end
      end
      StVerify: begin
        if (cnt_q == CntW'(SETTLE_CYCLES)) begin
          aligned_d[bit_idx_q] = samp_q[1];
          if (!valid(samp_q) && !bit_fail_q[bit_idx_q]) begin
            bit_fail_d[bit_idx_q] = 1'b1;
            if (err_q == ErrNone) err_d = ErrInvalCentre;
          end
          mem_we  = 1'b1;
          state_d = StNext;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StNext: begin
        if (bit_idx_q == BitW'(DATA_WIDTH - 1)) begin
          state_d = StDone;
        end else begin
          bit_idx_d = bit_idx_q + 1'b1;
          state_d   = StBitRst;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      err_q      <= ErrNone;
      bit_idx_q  <= '0;
      tap_q      <= '0;
      target_q   <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      first_q    <= '0;
      good_q     <= 1'b0;
      rst_mode_q <= 1'b0;
      phase_q    <= 1'b0;
      inc_q      <= 1'b1;
      dly_en_q   <= '0;
      dly_rst_q  <= '1;
      aligned_q  <= '1;
      bit_fail_q <= '0;
    end else begin
      state_q    <= state_d;
      err_q      <= err_d;
      bit_idx_q  <= bit_idx_d;
      tap_q      <= tap_d;
      target_q   <= target_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      first_q    <= first_d;
      good_q     <= good_d;
      rst_mode_q <= rst_mode_d;
      phase_q    <= phase_d;
      inc_q      <= inc_d;
      dly_en_q   <= dly_en_d;
      dly_rst_q  <= dly_rst_d;
      aligned_q  <= aligned_d;
      bit_fail_q <= bit_fail_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || mem_clear) begin
      for (int i = 0; i < DATA_WIDTH; i++) begin
        tap_mem[i] <= '0;
        win_mem[i] <= '0;
      end
    end else if (mem_we) begin
      tap_mem[bit_idx_q] <= tap_q;
      win_mem[bit_idx_q] <= len_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_tap_q <= '0;
      rd_win_q <= '0;
    end else if (32'(rd_bit_sel) < DATA_WIDTH) begin
      rd_tap_q <= tap_mem[rd_bit_sel];
      rd_win_q <= win_mem[rd_bit_sel];
    end else begin
      rd_tap_q <= '0;
      rd_win_q <= '0;
    end
  end

  assign train_done    = (state_q == StDone);
  assign train_fail    = train_done & (|bit_fail_q);
  assign dly_inc_dec_n = {DATA_WIDTH{inc_q}};
  assign dly_en        = dly_en_q;
  assign dly_rst       = dly_rst_q;
  assign aligned       = aligned_q;
  assign bit_fail      = bit_fail_q;
  assign rd_tap        = rd_tap_q;
  assign rd_win        = rd_win_q;
  assign state_prb     = state_q;
  assign error_prb     = err_q;

endmodule

// File: tb/tb_qdrc_phy_bit_deskew.sv
// Self-checking bench: emulates per-bit IODELAY lines and eye patterns, and
// checks training results against an eye-scan model.
module tb_qdrc_phy_bit_deskew;

  localparam int DW = 36, NT = 32, TW = 5, SETTLE = 6, SAMPLE = 8, MINW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          train_start = 1'b0;
  logic          train_done, train_fail;
  logic [DW-1:0] q_rise, q_fall, dly_inc_dec_n, dly_en, dly_rst, aligned, bit_fail;
  logic [5:0]    rd_bit_sel = '0;
  logic [TW-1:0] rd_tap;
  logic [TW:0]   rd_win;
  logic [3:0]    state_prb, error_prb;

  // Eye code per tap: 10/01 stable pattern, 00 toggling data, 11 stuck invalid.
  logic [1:0] eye [DW][NT];
  int         dtap [DW];
  int         rst_cnt [DW];
  int         bad_pulse;
  bit         ph;
  int         exp_tap [DW];
  int         exp_len [DW];
  bit         exp_fail [DW];
  bit         exp_al [DW];
  int         checks = 0;
  int         failures = 0;

  initial forever #5 clk = ~clk;

  qdrc_phy_bit_deskew #(
    .DATA_WIDTH    (DW),
    .NTAPS         (NT),
    .TAPW          (TW),
    .SETTLE_CYCLES (SETTLE),
    .SAMPLE_CYCLES (SAMPLE),
    .MIN_WINDOW    (MINW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .train_start   (train_start),
    .train_done    (train_done),
    .train_fail    (train_fail),
    .q_rise        (q_rise),
    .q_fall        (q_fall),
    .dly_inc_dec_n (dly_inc_dec_n),
    .dly_en        (dly_en),
    .dly_rst       (dly_rst),
    .aligned       (aligned),
    .bit_fail      (bit_fail),
    .rd_bit_sel    (rd_bit_sel),
    .rd_tap        (rd_tap),
    .rd_win        (rd_win),
    .state_prb     (state_prb),
    .error_prb     (error_prb)
  );

  // IODELAY emulation and data source.
  initial begin
    logic [1:0] v;
    bad_pulse = 0;
    ph = 1'b0;
    q_rise = '0;
    q_fall = '0;
    for (int b = 0; b < DW; b++) begin
      dtap[b] = 0;
      rst_cnt[b] = 0;
    end
    forever begin
      @(negedge clk);
      if ($countones(dly_en) > 1 || (dly_en != '0 && dly_rst != '0)) bad_pulse++;
      for (int b = 0; b < DW; b++) begin
        if (dly_rst[b]) begin
          dtap[b] = 0;
          if (dly_rst != '1) rst_cnt[b]++;
        end else if (dly_en[b]) begin
          dtap[b] = dly_inc_dec_n[b] ? dtap[b] + 1 : dtap[b] - 1;
        end
      end
      ph = ~ph;
      for (int b = 0; b < DW; b++) begin
        v = eye[b][dtap[b] & (NT - 1)];
        if (v == 2'b00) v = ph ? 2'b10 : 2'b01;
        q_rise[b] = v[1];
        q_fall[b] = v[0];
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic clear_eye(input int b, input bit stuck);
    for (int t = 0; t < NT; t++)
      eye[b][t] = (stuck && $urandom_range(3, 0) == 0) ? 2'b11 : 2'b00;
  endtask

  task automatic fill(input int b, input int s, input int l, input logic [1:0] p);
    for (int t = s; t < s + l && t < NT; t++) eye[b][t] = p;
  endtask

  task automatic rand_eye(input int b);
    int l, s;
    clear_eye(b, 1'b1);
    l = $urandom_range(20, MINW);
    s = $urandom_range(NT - l, 0);
    fill(b, s, l, ($urandom_range(1, 0) == 1) ? 2'b10 : 2'b01);
    l = $urandom_range(6, 1);
    s = $urandom_range(NT - l, 0);
    for (int t = s; t < s + l; t++)
      if (eye[b][t][1] == eye[b][t][0]) eye[b][t] = ($urandom_range(1, 0) == 1) ? 2'b10 : 2'b01;
  endtask

  // Longest run of one stable pattern, lowest start on ties.
  task automatic build_model();
    int bs, bl, l;
    for (int b = 0; b < DW; b++) begin
      bs = 0;
      bl = 0;
      for (int s = 0; s < NT; s++) begin
        l = 0;
        if (eye[b][s] == 2'b10 || eye[b][s] == 2'b01)
          while (s + l < NT && eye[b][s + l] == eye[b][s]) l++;
        if (l > bl) begin
          bl = l;
          bs = s;
        end
      end
      exp_len[b]  = bl;
      exp_fail[b] = (bl < MINW);
      exp_tap[b]  = (bl > 0) ? bs + (bl - 1) / 2 : 0;
      exp_al[b]   = eye[b][exp_tap[b]][1];
    end
  endtask

  task automatic rd(input int b, output logic [TW-1:0] t, output logic [TW:0] w);
    rd_bit_sel = 6'(b);
    @(posedge clk);
    @(negedge clk);
    t = rd_tap;
    w = rd_win;
  endtask

  task automatic run_training(input string tag);
    int n;
    @(negedge clk);
    train_start = 1'b1;
    @(negedge clk);
    train_start = 1'b0;
    check({tag, "_busy"}, train_done, 1'b0);
    n = 0;
    while (train_done !== 1'b1 && n < 60000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, train_done, 1'b1);
  endtask

  task automatic verify(input string tag);
    logic [TW-1:0] t;
    logic [TW:0]   w;
    logic [DW-1:0] ef, ea, am;
    ef = '0;
    ea = '0;
    am = '0;
    for (int b = 0; b < DW; b++) begin
      rd(b, t, w);
      check($sformatf("%s_tap%0d", tag, b), t, exp_tap[b]);
      check($sformatf("%s_win%0d", tag, b), w, exp_len[b]);
      check($sformatf("%s_iodly%0d", tag, b), dtap[b], exp_tap[b]);
      ef[b] = exp_fail[b];
      if (exp_len[b] > 0) begin
        am[b] = 1'b1;
        ea[b] = exp_al[b];
      end
    end
    check({tag, "_bit_fail"}, bit_fail, ef);
    check({tag, "_aligned"}, aligned & am, ea);
    check({tag, "_train_fail"}, train_fail, |ef);
    check({tag, "_error"}, error_prb, (|ef) ? 4'd1 : 4'd0);
  endtask

  initial begin
    logic [TW-1:0] t;
    logic [TW:0]   w;
    int            base0, base4, base7, n;

    // Training 1: directed eyes on bits 0..3, random eyes elsewhere.
    for (int b = 0; b < DW; b++) rand_eye(b);
    for (int b = 0; b < 4; b++) clear_eye(b, 1'b0);
    fill(0, 5, 16, 2'b10);
    fill(1, 8, 16, 2'b01);
    fill(2, 2, 5, 2'b10);
    fill(2, 10, 16, 2'b10);
    fill(3, 3, 7, 2'b10);
    fill(3, 10, 5, 2'b01);
    build_model();

    repeat (3) @(negedge clk);
    check("rst_state", state_prb, 4'd0);
    check("rst_dly_rst", dly_rst, {DW{1'b1}});
    check("rst_dly_en", dly_en, '0);
    check("rst_inc", dly_inc_dec_n, {DW{1'b1}});
    check("rst_aligned", aligned, {DW{1'b1}});
    check("rst_bit_fail", bit_fail, '0);
    check("rst_done", {train_done, train_fail}, 2'b00);
    check("rst_error", error_prb, 4'd0);
    reset = 1'b0;
    @(negedge clk);
    check("rst_dly_rst_drop", dly_rst, '0);
    rd(0, t, w);
    check("rst_rd", {t, w}, '0);

    run_training("t1");
    verify("t1");
    rd(0, t, w);
    check("t1_bit0_centre", {t, w}, {5'd12, 6'd16});
    rd(1, t, w);
    check("t1_bit1_centre", t, 5'd15);
    check("t1_bit1_aligned", aligned[1], 1'b0);
    rd(2, t, w);
    check("t1_bit2_widest", {t, w}, {5'd17, 6'd16});
    rd(3, t, w);
    check("t1_bit3_adjacent", {t, w}, {5'd6, 6'd7});
    check("t1_bit3_aligned", aligned[3], 1'b1);

    // Training 2 from DONE after an eye shift: bit 4 empty, bit 35 too narrow.
    for (int b = 0; b < DW; b++) rand_eye(b);
    clear_eye(4, 1'b1);
    clear_eye(35, 1'b0);
    fill(35, $urandom_range(NT - 3, 0), 3, ($urandom_range(1, 0) == 1) ? 2'b10 : 2'b01);
    build_model();
    base0 = rst_cnt[0];
    base4 = rst_cnt[4];
    run_training("t2");
    verify("t2");
    check("t2_bit35_fail", bit_fail[35], 1'b1);
    check("t2_train_fail", train_fail, 1'b1);
    check("t2_error", error_prb, 4'd1);
    check("t2_bit0_rst_pulses", rst_cnt[0] - base0, 1);
    check("t2_bit4_rst_pulses", rst_cnt[4] - base4, 2);
    rd(4, t, w);
    check("t2_bit4_empty", {t, w}, '0);

    // Training 3: reset during the bit 7 sweep.
    for (int b = 0; b < DW; b++) rand_eye(b);
    base7 = rst_cnt[7];
    @(negedge clk);
    train_start = 1'b1;
    @(negedge clk);
    train_start = 1'b0;
    n = 0;
    while (rst_cnt[7] == base7 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("t3_bit7_reached", rst_cnt[7] - base7, 1);
    repeat (150) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("t3_abort_state", state_prb, 4'd0);
    check("t3_abort_dly_rst", dly_rst, {DW{1'b1}});
    check("t3_abort_dly_en", dly_en, '0);
    check("t3_abort_inc", dly_inc_dec_n, {DW{1'b1}});
    check("t3_abort_results", {aligned, bit_fail}, {{DW{1'b1}}, {DW{1'b0}}});
    check("t3_abort_status", {train_done, error_prb}, 5'd0);
    reset = 1'b0;
    @(negedge clk);
    check("t3_idle_hold", {state_prb, dly_rst}, {4'd0, {DW{1'b0}}});
    rd(0, t, w);
    check("t3_rd_cleared", {t, w}, '0);
    check("pulse_onehot", bad_pulse, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/qdrc_phy_bit_deskew.md
Name: qdrc_phy_bit_deskew

Overview:
Next-generation per-bit read-capture trainer for the QDR PHY.
- Sequentially sweeps each data bit's IODELAY across the full tap range.
- Finds the widest stable eye per bit and centres the delay in it.
- Reports half-word alignment, per-bit failure, and per-bit tap and window width through a readback port.
- Sits between the IDDR capture outputs and the IODELAY control pins; retraining is supported without reset.

Parameters:
DATA_WIDTH, 36, number of data bits trained
NTAPS, 32, IODELAY taps available (power of two)
TAPW, 5, width of tap counters, log2(NTAPS)
SETTLE_CYCLES, 16, wait cycles after any delay change before sampling
SAMPLE_CYCLES, 16, consecutive samples that must agree for a tap to be good
MIN_WINDOW, 4, minimum good-tap run for a bit to pass

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
train_start  in  1  level; starts training when IDLE or DONE
train_done  out  1  high when all bits are processed, until next start or reset
train_fail  out  1  OR of bit_fail, valid with train_done
q_rise  in  DATA_WIDTH  IDDR rising-edge data
q_fall  in  DATA_WIDTH  IDDR falling-edge data
dly_inc_dec_n  out  DATA_WIDTH  replicated increment (1) / decrement (0)
dly_en  out  DATA_WIDTH  one-cycle IODELAY step pulse, one-hot on current bit
dly_rst  out  DATA_WIDTH  one-cycle IODELAY reset pulse
aligned  out  DATA_WIDTH  1 = rise sample at centre is 1 (no half-word slip)
bit_fail  out  DATA_WIDTH  1 = bit had no window of at least MIN_WINDOW taps
rd_bit_sel  in  6  readback bit index (ceil(log2(DATA_WIDTH)) bits)
rd_tap  out  TAPW  final tap of the selected bit, registered (1-cycle latency)
rd_win  out  TAPW+1  best window length of the selected bit, registered
state_prb  out  4  current state code
error_prb  out  4  first error code latched since start

Behaviour:
- Input capture
  - q_rise/q_fall pass through two register stages, then the bit_index mux, then one more register, giving sample s = {rise, fall}.
  - s is valid iff rise XOR fall.
- Reset values
  - state IDLE; train_done/train_fail 0; aligned all ones; bit_fail 0; error NONE(0).
  - dly_en 0; dly_inc_dec_n 1; stored taps and windows 0.
  - dly_rst is all ones on the cycle after each reset-high cycle.
  - Reset mid-operation aborts immediately, with the same values.
- States (codes 0-9)
  - IDLE: on train_start, clear results and error, set bit_index=0, go to BITRST.
  - BITRST: dly_rst pulse on the current bit; tap=0; tracker cleared; go to SETTLE.
  - SETTLE: count SETTLE_CYCLES, then go to SAMPLE.
  - SAMPLE: take SAMPLE_CYCLES samples.
    - A tap is good iff every sample is valid and equal to the first sample.
    - Feed (good, pattern, tap) to the tracker.
    - If tap < NTAPS-1: go to STEP, else go to CALC.
  - STEP: dly_en pulse with inc=1; tap+1; go to SETTLE.
  - CALC: best run from tracker.
    - If len >= MIN_WINDOW: target = start + (len-1)/2 (floor).
    - Otherwise: set bit_fail[bit], error NO_WINDOW(1); target = (len>0) ? start + (len-1)/2 : 0.
    - Go to BACK.
  - BACK: while tap > target, issue one dec pulse per 2 cycles (pulse, idle). At tap == target, go to VSETTLE.
    - target==0 with len==0 uses a dly_rst pulse instead of stepping down.
  - VSETTLE/VERIFY: settle, then sample once.
    - aligned[bit] <= rise.
    - If invalid and the bit has not already failed: set bit_fail, error INVAL_CENTRE(2).
    - Store tap and len for the bit.
  - NEXT: if bit_index < DATA_WIDTH-1, increment bit_index and go to BITRST; else go to DONE.
  - DONE: train_done=1; train_fail = |bit_fail. train_start restarts from IDLE actions (retrain).
- train_start is ignored in all other states.
- Tracker rule
  - A run is consecutive good taps with an identical pattern.
  - A bad tap or a pattern change ends the run; a pattern change starts a new run at that tap.
  - Strictly longer runs replace the best; ties keep the lowest start.
  - The final run is closed at tap NTAPS-1.
- Only the current bit's dly_en/dly_rst is ever asserted; at most one pulse per cycle.

Decomposition:
- Package qdrc_bit_deskew_pkg holds:
  - state codes;
  - error codes NONE=0, NO_WINDOW=1, INVAL_CENTRE=2;
  - the valid() function.
- Sub-module qdrc_bit_window_tracker: clear, strobe, good, pattern[1:0], tap in; best_start, best_len out.
  - Registered; results valid one cycle after the last strobe.

Test Plan:
- Eye model for bit 0: pattern 10 on taps 5..20, toggling elsewhere -> rd_tap=12, rd_win=16, aligned[0]=1, bit_fail=0.
- Pattern 01 on taps 8..23 -> rd_tap=15, aligned=0, train_fail=0.
- Two windows, taps 2..6 and 10..25 (both 10) -> selects start 10, len 16, tap 17.
- Adjacent 10 on 3..9 and 01 on 10..14 (length 7 vs 5) -> tap 6, aligned 1.
- Window of only 3 taps on bit 35 -> bit_fail[35]=1, train_fail=1 at done, error_prb=1, other bits unaffected.
- No valid tap on a bit -> dly_rst pulse in BACK, rd_tap=0, rd_win=0.
- Reset asserted during the bit 7 sweep -> next cycle state 0, dly_rst all ones.
- Second train_start from DONE after the eye shift -> fresh results and train_done re-asserts.
